wb_regfile: RTL and testbench

//  Write-back end of the MEM/WB pipeline register. Consumes the registered MEM/WB

---
 rtl/wb_regfile.sv | 64 ++++++
 tb/tb_wb_regfile.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage and 2-read/1-write register file with a retired-write counter.
// Optional WB_BYPASS_EN: same-cycle write-through from the write-back port to both read ports.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemtoReg_in,
  input  logic              RegWrite_in,
  input  logic [DATA_W-1:0] Mem_Data_in,
  input  logic [DATA_W-1:0] ALU_Data_in,
  input  logic [ADDR_W-1:0] Reg_Write_in,
  input  logic [ADDR_W-1:0] Read_Reg1,
  input  logic [ADDR_W-1:0] Read_Reg2,
  output logic [DATA_W-1:0] Read_Data1,
  output logic [DATA_W-1:0] Read_Data2,
  output logic [DATA_W-1:0] WB_Data_out,
  output logic              WB_Valid_out,
  output logic [CNT_W-1:0]  Wr_Count_out
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  wr_count;

  assign WB_Data_out  = MemtoReg_in ? Mem_Data_in : ALU_Data_in;
  // Writes to register 0 are not architectural, so they neither commit nor count.
  assign WB_Valid_out = RegWrite_in && (Reg_Write_in != '0);
  assign Wr_Count_out = wr_count;

  // NOTE: the register array is cleared on reset because software relies on
  // zeroed registers; this forces flops rather than a RAM macro. All state
  // here uses non-blocking assignments so every update lands at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (WB_Valid_out) begin
      regs[Reg_Write_in] <= WB_Data_out;
      wr_count           <= wr_count + CNT_W'(1);
    end
  end

  // NOTE: each combinational output gets a default first so no latch is inferred.
  always_comb begin
    Read_Data1 = regs[Read_Reg1];
`ifdef WB_BYPASS_EN
    if (WB_Valid_out && (Read_Reg1 == Reg_Write_in)) Read_Data1 = WB_Data_out;
`endif
    if (rst || (Read_Reg1 == '0)) Read_Data1 = '0;
  end

  always_comb begin
    Read_Data2 = regs[Read_Reg2];
`ifdef WB_BYPASS_EN
    if (WB_Valid_out && (Read_Reg2 == Reg_Write_in)) Read_Data2 = WB_Data_out;
`endif
    if (rst || (Read_Reg2 == '0)) Read_Data2 = '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected outputs, a negedge monitor compares.
// The DUT is built with CNT_W=4 so the counter wrap is reachable quickly.
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              MemtoReg_in;
  logic              RegWrite_in;
  logic [DATA_W-1:0] Mem_Data_in;
  logic [DATA_W-1:0] ALU_Data_in;
  logic [ADDR_W-1:0] Reg_Write_in;
  logic [ADDR_W-1:0] Read_Reg1;
  logic [ADDR_W-1:0] Read_Reg2;
  logic [DATA_W-1:0] Read_Data1;
  logic [DATA_W-1:0] Read_Data2;
  logic [DATA_W-1:0] WB_Data_out;
  logic              WB_Valid_out;
  logic [CNT_W-1:0]  Wr_Count_out;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemtoReg_in  (MemtoReg_in),
    .RegWrite_in  (RegWrite_in),
    .Mem_Data_in  (Mem_Data_in),
    .ALU_Data_in  (ALU_Data_in),
    .Reg_Write_in (Reg_Write_in),
    .Read_Reg1    (Read_Reg1),
    .Read_Reg2    (Read_Reg2),
    .Read_Data1   (Read_Data1),
    .Read_Data2   (Read_Data2),
    .WB_Data_out  (WB_Data_out),
    .WB_Valid_out (WB_Valid_out),
    .Wr_Count_out (Wr_Count_out)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {S_RD1, S_RD2, S_WBD, S_WBV, S_CNT} sel_e;
  typedef struct {
    sel_e        sel;
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Monitor: mid-cycle, compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        S_RD1:   act = Read_Data1;
        S_RD2:   act = Read_Data2;
        S_WBD:   act = WB_Data_out;
        S_WBV:   act = {31'd0, WB_Valid_out};
        default: act = {28'd0, Wr_Count_out};
      endcase
      n_vec++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic drive(input logic r, input logic we, input logic m2r,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] dst, input logic [4:0] rr1, input logic [4:0] rr2);
    rst          = r;
    RegWrite_in  = we;
    MemtoReg_in  = m2r;
    Mem_Data_in  = mem;
    ALU_Data_in  = alu;
    Reg_Write_in = dst;
    Read_Reg1    = rr1;
    Read_Reg2    = rr2;
  endtask

  task automatic expect_val(input sel_e s, input string n, input logic [31:0] v);
    exp_t e;
    e.sel  = s;
    e.name = n;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd31);
    expect_val(S_CNT, "reset_cnt", 32'd0);
    expect_val(S_RD1, "reset_r9", 32'd0);
    expect_val(S_RD2, "reset_r31", 32'd0);
    tick();

    // Random writes, then reset for two cycles
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, $urandom | 32'h1, 5'(i * 7), 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
    expect_val(S_CNT, "pre_reset_cnt", 32'd4);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd14);
    expect_val(S_RD1, "rst_held_r7", 32'd0);
    expect_val(S_RD2, "rst_held_r14", 32'd0);
    tick();
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
      expect_val(S_RD1, $sformatf("post_reset_rd1_r%0d", i), 32'd0);
      expect_val(S_RD2, $sformatf("post_reset_rd2_r%0d", 31 - i), 32'd0);
      if (i == 0) expect_val(S_CNT, "post_reset_cnt", 32'd0);
      tick();
    end

    // ALU write to r5
    drive(1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h1234_5678, 5'd5, 5'd5, 5'd7);
    expect_val(S_WBD, "alu_wbdata", 32'h1234_5678);
    expect_val(S_WBV, "alu_wbvalid", 32'd1);
    expect_val(S_RD1, "alu_same_cycle_r5", BYPASS ? 32'h1234_5678 : 32'd0);
    expect_val(S_RD2, "alu_other_idx_r7", 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    expect_val(S_RD1, "alu_next_cycle_r5", 32'h1234_5678);
    expect_val(S_CNT, "alu_cnt", 32'd1);
    tick();

    // Load write to $0 is dropped
    drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd0, 5'd5, 5'd0);
    expect_val(S_WBD, "load_wbdata", 32'hDEAD_BEEF);
    expect_val(S_WBV, "load_r0_wbvalid", 32'd0);
    expect_val(S_RD2, "load_r0_same", 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd5, 5'd0);
    expect_val(S_RD2, "load_r0_next", 32'd0);
    expect_val(S_RD1, "load_r5_kept", 32'h1234_5678);
    expect_val(S_CNT, "load_r0_cnt", 32'd1);
    expect_val(S_WBV, "regwrite_low_wbvalid", 32'd0);
    tick();

    // Same-cycle read/write of r7 (old value 1)
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0001, 5'd7, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hA5A5_A5A5, 5'd7, 5'd7, 5'd7);
    expect_val(S_RD1, "raw_same_cycle_rd1", BYPASS ? 32'hA5A5_A5A5 : 32'h0000_0001);
    expect_val(S_RD2, "raw_same_cycle_rd2", BYPASS ? 32'hA5A5_A5A5 : 32'h0000_0001);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    expect_val(S_RD1, "raw_next_rd1", 32'hA5A5_A5A5);
    expect_val(S_RD2, "raw_next_rd2", 32'hA5A5_A5A5);
    expect_val(S_CNT, "raw_cnt", 32'd3);
    tick();

    // Reset dominates a simultaneous write
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0033, 5'd3, 5'd3, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00FF, 5'd3, 5'd3, 5'd5);
    expect_val(S_WBV, "rst_wr_wbvalid", 32'd1);
    expect_val(S_WBD, "rst_wr_wbdata", 32'h0000_00FF);
    expect_val(S_RD1, "rst_wr_rd_held", 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd5);
    expect_val(S_RD1, "rst_wr_r3", 32'd0);
    expect_val(S_RD2, "rst_wr_r5", 32'd0);
    expect_val(S_CNT, "rst_wr_cnt", 32'd0);
    tick();

    // Counter wrap with CNT_W=4: idle and $0 cycles interleaved
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h100 + 32'(i), 5'(i + 1), 5'd0, 5'd0);
      tick();
      if (i == 14) begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF, 5'd9, 5'd0, 5'd0);
        expect_val(S_CNT, "wrap_cnt_15", 32'd15);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF, 5'd0, 5'd0, 5'd0);
        expect_val(S_CNT, "wrap_idle_cnt_15", 32'd15);
        tick();
      end
      if (i == 15) begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_val(S_CNT, "wrap_cnt_0", 32'd0);
        tick();
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd17, 5'd9);
    expect_val(S_CNT, "wrap_cnt_1", 32'd1);
    expect_val(S_RD1, "wrap_r17", 32'h0000_0110);
    expect_val(S_RD2, "wrap_r9", 32'h0000_0108);
    tick();

    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
